crt_loader: RTL and testbench
=============================

# crt_loader

Streaming parser for `.CRT` cartridge images, placed between the download channel and the cartridge mapper. It consumes the image byte by byte and validates the 64-byte CRT header, latching cart type and EXROM/GAME. It writes each CHIP packet's payload into SDRAM on 8 KB-aligned slots and emits one bank-descriptor strobe per CHIP. Its outputs drive the mapper's `cart_id`/`cart_exrom`/`cart_game`/`cart_bank_*`/`cart_attached`/`cart_loading` inputs directly.

## Interface
- `CART_BASE`, default 24'h100000: SDRAM base of the ROM image region.
- `MAX_BYTES`, default 21'h100000: payload capacity in bytes (1 MB).
- `clk32`  in  1  system clock.
- `reset`  in  1  **synchronous, active-low** reset; clock `clk32`.
- `dl_active`  in  1  CRT download in progress.
- `dl_wr`  in  1  one-cycle strobe, `dl_data` valid; at most one per cycle.
- `dl_data`  in  8  image byte.
- `cart_detach`  in  1  one-cycle strobe, detaches the cartridge.
- `mem_addr`  out  24  SDRAM write address.
- `mem_data`  out  8  SDRAM write data.
- `mem_wr`  out  1  one-cycle write strobe.
- `cart_id`  out  16  header hardware type.
- `cart_exrom`  out  8  header byte 0x18.
- `cart_game`  out  8  header byte 0x19.
- `cart_bank_num`  out  16  CHIP bank number.
- `cart_bank_laddr`  out  16  CHIP load address.
- `cart_bank_size`  out  16  CHIP image size.
- `cart_bank_type`  out  8  CHIP type, low byte.
- `cart_bank_raddr`  out  24  SDRAM address of the CHIP payload.
- `cart_bank_wr`  out  1  one-cycle descriptor strobe.
- `cart_loading`  out  1  load in progress.
- `cart_attached`  out  1  valid image loaded.
- `load_error`  out  1  last load failed.

## Operation
- All multi-byte fields are big-endian.
- Byte counter `pos` resets per section.
- **States:** IDLE, HDR, HSKIP, CHDR, DATA, PSKIP, ERR.
- **Download start** (rising `dl_active`), from any state:
  - go to HDR;
  - clear `pos`, `chip_cnt`, write pointer `wp` (21 bits), `cart_attached`, `load_error`;
  - set `cart_loading`.
- **HDR:**
  - Bytes 0–15 must equal "C64 CARTRIDGE   " (ASCII, three trailing spaces). Any mismatch → ERR.
  - Bytes 0x10–0x13 → `hlen`; 0x16–0x17 → `cart_id`; 0x18 → `cart_exrom`; 0x19 → `cart_game`.
  - After byte 0x3F: `hlen` > 0x40 → HSKIP (skip `hlen`−0x40 bytes, then CHDR); otherwise → CHDR.
  - `hlen` < 0x40 is treated as 0x40.
- **CHDR** (16 bytes):
  - Bytes 0–3 must equal "CHIP", else → ERR.
  - Bytes 4–7 → `plen`; 8–9 → type; 10–11 → `cart_bank_num`; 12–13 → `cart_bank_laddr`; 14–15 → `cart_bank_size`.
  - On the cycle after byte 15: pulse `cart_bank_wr` with `cart_bank_raddr` = CART_BASE + `wp`, and increment `chip_cnt`.
  - Next state: DATA if size ≠ 0, otherwise PSKIP.
- **DATA:**
  - Each byte is written to CART_BASE + `wp`, then `wp` increments.
  - After `size` bytes, `wp` rounds up to the next multiple of 0x2000 (no change if already aligned).
  - Remaining `plen`−16−`size` bytes (if > 0) → PSKIP, then CHDR.
- **Overflow:** a write with `wp` ≥ MAX_BYTES is suppressed; → ERR.
- **ERR:** ignores bytes; sets `load_error`.
- **Download end** (falling `dl_active`):
  - `cart_loading` → 0.
  - `cart_attached` ← (state ≠ ERR and `chip_cnt` ≥ 1).
  - State → IDLE.
  - Truncation inside DATA/PSKIP still attaches.
  - Truncation in HDR/HSKIP: sets `load_error`, does not attach.
- `dl_wr` while not `dl_active` is ignored.
- `cart_detach` clears `cart_attached`. If coincident with download start, start takes priority; the result is the same (cleared).

## Timing
- **Reset values:** all outputs 0, state IDLE.
- `mem_wr`/`mem_addr`/`mem_data` are registered, 1 cycle after the `dl_wr` carrying the payload byte.
- `cart_bank_wr` is 1 cycle after the `dl_wr` of CHIP header byte 15.
- The `cart_bank_*` fields stay stable until the next CHIP's header byte 8.
- Back-to-back `dl_wr` is sustained at one byte per cycle; no backpressure.
- `cart_attached` and `cart_loading` update 1 cycle after the `dl_active` edge.
- Reset asserted mid-download aborts the load: state IDLE, nothing attached. A load resumes only on a new rising edge of `dl_active`.

## Test plan
1. **Generic 8K:** header with type 0, exrom 0, game 1, hlen 0x40; one CHIP with bank 0, laddr 0x8000, size 0x2000.
   - `cart_bank_wr` once, `raddr` = 0x100000.
   - 8192 `mem_wr` covering 0x100000–0x101FFF.
   - End: `cart_attached` = 1, `cart_id` = 0, `cart_exrom` = 0, `cart_game` = 1.
2. **Two CHIPs:** size 0x4000 then size 0x1000, with hlen 0x50 (16 skipped bytes).
   - `raddr` 0x100000 then 0x104000.
   - Second chip writes end at 0x104FFF.
   - Skipped header bytes produce no writes.
3. **Padding:** `plen` = 0x2020, size 0x2000.
   - 16 PSKIP bytes produce no `mem_wr`.
   - Next CHIP's `raddr` = 0x102000.
4. **Bad signature:** byte 5 corrupted.
   - `load_error` = 1, no `mem_wr`, no `cart_bank_wr`.
   - End: `cart_attached` = 0.
5. **Truncation and reset:**
   - `dl_active` drops halfway through CHIP data → `cart_attached` = 1.
   - Reset during HDR, then a fresh full download → identical to scenario 1.
6. **Overflow:** 129 CHIPs of 8K each.
   - 129th CHIP has `raddr` 0x200000; its first write is suppressed.
   - ERR, `cart_attached` = 0.

Source files
------------

// File: rtl/crt_loader_if.sv
// crt_loader_if: download byte channel and SDRAM write port of the CRT loader
//   dl_active  download in progress           (master -> slave)
//   dl_wr      one-cycle byte strobe           (master -> slave)
//   dl_data    image byte                      (master -> slave)
//   mem_addr   SDRAM write address             (slave -> master)
//   mem_data   SDRAM write data                (slave -> master)
//   mem_wr     one-cycle SDRAM write strobe    (slave -> master)
interface crt_loader_if;
    logic        dl_active;
    logic        dl_wr;
    logic [7:0]  dl_data;
    logic [23:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_wr;
    modport master (output dl_active, dl_wr, dl_data, input mem_addr, mem_data, mem_wr);
    modport slave  (input dl_active, dl_wr, dl_data, output mem_addr, mem_data, mem_wr);
endinterface

// File: rtl/crt_loader.sv
// crt_loader: streaming .CRT parser feeding SDRAM and the cartridge mapper
//   clk32, reset (sync, active-low)
//   dl            download channel in / SDRAM write port out (crt_loader_if.slave)
//   cart_detach   one-cycle strobe clearing cart_attached
//   cart_id/cart_exrom/cart_game      header fields
//   cart_bank_*   CHIP descriptor, strobed by cart_bank_wr
//   cart_loading, cart_attached, load_error   load status
module crt_loader #(
    parameter logic [23:0] CART_BASE = 24'h100000,
    parameter logic [20:0] MAX_BYTES = 21'h100000
) (
    input  logic         clk32,
    input  logic         reset,
    crt_loader_if.slave  dl,
    input  logic         cart_detach,
    output logic [15:0]  cart_id,
    output logic [7:0]   cart_exrom,
    output logic [7:0]   cart_game,
    output logic [15:0]  cart_bank_num,
    output logic [15:0]  cart_bank_laddr,
    output logic [15:0]  cart_bank_size,
    output logic [7:0]   cart_bank_type,
    output logic [23:0]  cart_bank_raddr,
    output logic         cart_bank_wr,
    output logic         cart_loading,
    output logic         cart_attached,
    output logic         load_error
);
    typedef enum logic [2:0] {IDLE, HDR, HSKIP, CHDR, DATA, PSKIP, ERR} state_t;
    localparam logic [127:0] HDR_SIG  = "C64 CARTRIDGE   ";
    localparam logic [31:0]  CHIP_SIG = "CHIP";
    state_t      state, state_n;
    logic        active_q, rise, fall, byte_en, overflow;
    logic [5:0]  pos;
    logic [31:0] hlen, plen, cnt, pad, pad_full;
    logic [20:0] wp, wp_inc, wp_align;
    logic [15:0] chip_cnt, size_full;
    logic [7:0]  hdr_byte, chip_byte;
    assign rise    = dl.dl_active && !active_q;
    assign fall    = !dl.dl_active && active_q;
    assign byte_en = dl.dl_wr && dl.dl_active && !rise;
    always_comb begin
        hdr_byte  = 8'(HDR_SIG >> {~pos[3:0], 3'b000});
        chip_byte = 8'(CHIP_SIG >> {~pos[1:0], 3'b000});
        // size is only complete together with CHIP header byte 15
        size_full = {cart_bank_size[7:0], dl.dl_data};
        pad_full  = plen > {16'd0, size_full} + 32'd16 ? plen - {16'd0, size_full} - 32'd16 : 32'd0;
        overflow  = wp >= MAX_BYTES;
        wp_inc    = wp + 21'd1;
        wp_align  = (wp_inc + 21'h1FFF) & ~21'h1FFF;
        state_n   = state;
        if (rise)
            state_n = HDR;
        else if (fall)
            state_n = IDLE;
        else if (byte_en)
            case (state)
                HDR:     state_n = pos < 6'd16 && dl.dl_data != hdr_byte ? ERR :
                                   pos == 6'd63 ? (hlen > 32'h40 ? HSKIP : CHDR) : HDR;
                HSKIP:   state_n = cnt == 32'd1 ? CHDR : HSKIP;
                CHDR:    state_n = pos < 6'd4 && dl.dl_data != chip_byte ? ERR :
                                   pos == 6'd15 ? (size_full != 16'd0 ? DATA : pad_full != 32'd0 ? PSKIP : CHDR) : CHDR;
                DATA:    state_n = overflow ? ERR : cnt == 32'd1 ? (pad != 32'd0 ? PSKIP : CHDR) : DATA;
                PSKIP:   state_n = cnt == 32'd1 ? CHDR : PSKIP;
                default: state_n = state;
            endcase
    end
    always_ff @(posedge clk32)
        state <= !reset ? IDLE : state_n;
    always_ff @(posedge clk32) begin
        if (!reset) begin
            // sampling dl_active here keeps an ongoing download from looking like a fresh start
            active_q        <= dl.dl_active;
            pos             <= '0;
            hlen            <= '0;
            plen            <= '0;
            cnt             <= '0;
            pad             <= '0;
            wp              <= '0;
            chip_cnt        <= '0;
            dl.mem_addr     <= '0;
            dl.mem_data     <= '0;
            dl.mem_wr       <= 1'b0;
            cart_id         <= '0;
            cart_exrom      <= '0;
            cart_game       <= '0;
            cart_bank_num   <= '0;
            cart_bank_laddr <= '0;
            cart_bank_size  <= '0;
            cart_bank_type  <= '0;
            cart_bank_raddr <= '0;
            cart_bank_wr    <= 1'b0;
            cart_loading    <= 1'b0;
            cart_attached   <= 1'b0;
            load_error      <= 1'b0;
        end else begin
            active_q     <= dl.dl_active;
            dl.mem_wr    <= 1'b0;
            cart_bank_wr <= 1'b0;
            if (rise) begin
                pos           <= '0;
                chip_cnt      <= '0;
                wp            <= '0;
                cart_attached <= 1'b0;
                load_error    <= 1'b0;
                cart_loading  <= 1'b1;
            end else if (fall) begin
                cart_loading  <= 1'b0;
                cart_attached <= state != ERR && state != HDR && state != HSKIP && chip_cnt != 16'd0;
                if (state == HDR || state == HSKIP)
                    load_error <= 1'b1;
            end else if (byte_en) begin
                // HDR wraps from 63 to 0 on its own; every other section restarts at 0
                pos <= state == HDR || (state == CHDR && pos != 6'd15) ? pos + 6'd1 : 6'd0;
                case (state)
                    HDR: begin
                        if (pos[5:2] == 4'h4)
                            hlen <= {hlen[23:0], dl.dl_data};
                        if (pos == 6'h16 || pos == 6'h17)
                            cart_id <= {cart_id[7:0], dl.dl_data};
                        if (pos == 6'h18)
                            cart_exrom <= dl.dl_data;
                        if (pos == 6'h19)
                            cart_game <= dl.dl_data;
                        cnt <= hlen - 32'h40;
                    end
                    CHDR: begin
                        if (pos[3:2] == 2'd1)
                            plen <= {plen[23:0], dl.dl_data};
                        if (pos == 6'd9)
                            cart_bank_type <= dl.dl_data;
                        if (pos[3:1] == 3'd5)
                            cart_bank_num <= {cart_bank_num[7:0], dl.dl_data};
                        if (pos[3:1] == 3'd6)
                            cart_bank_laddr <= {cart_bank_laddr[7:0], dl.dl_data};
                        if (pos[3:1] == 3'd7)
                            cart_bank_size <= {cart_bank_size[7:0], dl.dl_data};
                        if (pos == 6'd15) begin
                            cart_bank_wr    <= 1'b1;
                            cart_bank_raddr <= CART_BASE + {3'b000, wp};
                            chip_cnt        <= chip_cnt + 16'd1;
                            pad             <= pad_full;
                            cnt             <= size_full != 16'd0 ? {16'd0, size_full} : pad_full;
                        end
                    end
                    DATA: begin
                        if (!overflow) begin
                            dl.mem_wr   <= 1'b1;
                            dl.mem_addr <= CART_BASE + {3'b000, wp};
                            dl.mem_data <= dl.dl_data;
                            wp          <= cnt == 32'd1 ? wp_align : wp_inc;
                        end
                        cnt <= cnt == 32'd1 ? pad : cnt - 32'd1;
                    end
                    HSKIP, PSKIP: cnt <= cnt - 32'd1;
                    default: ;
                endcase
                if (state_n == ERR)
                    load_error <= 1'b1;
            end
            if (cart_detach)
                cart_attached <= 1'b0;
        end
    end
endmodule

// File: tb/tb_crt_loader.sv
// tb_crt_loader: randomized image bench for crt_loader against an image-level reference model
module tb_crt_loader;
    localparam logic [23:0] BASE = 24'h100000;
    localparam int          MAXB = 'h8000;
    logic        clk32 = 1'b0;
    logic        reset = 1'b0;
    logic        cart_detach = 1'b0;
    logic [15:0] cart_id, cart_bank_num, cart_bank_laddr, cart_bank_size;
    logic [7:0]  cart_exrom, cart_game, cart_bank_type;
    logic [23:0] cart_bank_raddr;
    logic        cart_bank_wr, cart_loading, cart_attached, load_error;
    int          errors = 0, checks = 0, cyc = 0;
    logic [7:0]  img[$];
    int          dcyc[$];
    logic [31:0] got_wa[$], exp_wa[$];
    int          got_wc[$], exp_wi[$];
    logic [79:0] got_d[$], exp_d[$];
    int          got_dc[$], exp_di[$];
    logic        m_att, m_err;
    logic [15:0] m_id;
    logic [7:0]  m_ex, m_gm;
    crt_loader_if bus();
    crt_loader #(.CART_BASE(BASE), .MAX_BYTES(21'h8000)) dut (
        .clk32(clk32), .reset(reset), .dl(bus), .cart_detach(cart_detach),
        .cart_id(cart_id), .cart_exrom(cart_exrom), .cart_game(cart_game),
        .cart_bank_num(cart_bank_num), .cart_bank_laddr(cart_bank_laddr),
        .cart_bank_size(cart_bank_size), .cart_bank_type(cart_bank_type),
        .cart_bank_raddr(cart_bank_raddr), .cart_bank_wr(cart_bank_wr),
        .cart_loading(cart_loading), .cart_attached(cart_attached), .load_error(load_error)
    );
    always #5 clk32 = ~clk32;
    always @(posedge clk32) cyc <= cyc + 1;
    always @(negedge clk32) begin
        if (bus.mem_wr) begin
            got_wa.push_back({bus.mem_addr, bus.mem_data});
            got_wc.push_back(cyc);
        end
        if (cart_bank_wr) begin
            got_d.push_back({cart_bank_raddr, cart_bank_num, cart_bank_laddr, cart_bank_size, cart_bank_type});
            got_dc.push_back(cyc);
        end
    end
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic logic [23:0] raddr_of(input int i);
        return i < got_d.size() ? got_d[i][79:56] : 24'hFFFFFF;
    endfunction
    function automatic logic [23:0] last_waddr();
        return got_wa.size() > 0 ? got_wa[got_wa.size()-1][31:8] : 24'hFFFFFF;
    endfunction
    task automatic put(input logic [31:0] v, input int nb);
        for (int i = nb - 1; i >= 0; i--) img.push_back(v[i*8 +: 8]);
    endtask
    task automatic mk_hdr(input int hlen, input logic [15:0] id, input logic [7:0] ex, input logic [7:0] gm);
        string s = "C64 CARTRIDGE   ";
        img.delete();
        for (int i = 0; i < 16; i++) img.push_back(s[i]);
        put(hlen, 4);
        put(32'h0100, 2);
        put({16'd0, id}, 2);
        img.push_back(ex);
        img.push_back(gm);
        while (img.size() < (hlen > 64 ? hlen : 64)) img.push_back(8'($urandom));
    endtask
    task automatic mk_chip(input int size, input int pad, input logic [15:0] typ, input logic [15:0] bank, input logic [15:0] laddr);
        string s = "CHIP";
        for (int i = 0; i < 4; i++) img.push_back(s[i]);
        put(16 + size + pad, 4);
        put({16'd0, typ}, 2);
        put({16'd0, bank}, 2);
        put({16'd0, laddr}, 2);
        put(size, 2);
        for (int i = 0; i < size + pad; i++) img.push_back(8'($urandom));
    endtask
    function automatic int be(input int p, input int nb);
        int v = 0;
        for (int i = 0; i < nb; i++) v = (v << 8) | int'(img[p + i]);
        return v;
    endfunction
    // parses the first n image bytes: expected writes, descriptors and final status
    task automatic model(input int n);
        string hs = "C64 CARTRIDGE   ";
        string cs = "CHIP";
        int p, hl, size, plen, wp = 0, chips = 0;
        exp_wa.delete(); exp_wi.delete(); exp_d.delete(); exp_di.delete();
        m_err = 1'b0;
        m_att = 1'b0;
        for (int i = 0; i < 16 && i < n; i++)
            if (img[i] != hs[i]) begin m_err = 1'b1; return; end
        if (n < 64) begin m_err = 1'b1; return; end
        m_id = 16'(be(22, 2));
        m_ex = img[24];
        m_gm = img[25];
        hl = be(16, 4) > 64 ? be(16, 4) : 64;
        if (n < hl) begin m_err = 1'b1; return; end
        p = hl;
        while (p < n) begin
            for (int i = 0; i < 4 && p + i < n; i++)
                if (img[p + i] != cs[i]) begin m_err = 1'b1; return; end
            if (n - p < 16) break;
            plen = be(p + 4, 4);
            size = be(p + 14, 2);
            exp_d.push_back({24'(BASE + wp), 16'(be(p + 10, 2)), 16'(be(p + 12, 2)), 16'(size), img[p + 9]});
            exp_di.push_back(p + 15);
            chips++;
            p += 16;
            for (int k = 0; k < size && p < n; k++) begin
                if (wp >= MAXB) begin m_err = 1'b1; return; end
                exp_wa.push_back({24'(BASE + wp), img[p]});
                exp_wi.push_back(p);
                wp++;
                p++;
            end
            wp = (wp + 'h1FFF) / 'h2000 * 'h2000;
            if (plen - 16 - size > 0) p += plen - 16 - size;
        end
        m_att = chips > 0;
    endtask
    task automatic load(input int n);
        model(n);
        dcyc.delete(); got_wa.delete(); got_wc.delete(); got_d.delete(); got_dc.delete();
        repeat (2) begin
            @(posedge clk32); #1;
            bus.dl_wr = 1'b1;
            bus.dl_data = 8'($urandom);
        end
        @(posedge clk32); #1;
        bus.dl_wr = 1'b0;
        bus.dl_active = 1'b1;
        @(posedge clk32); #1;
        check("loading_start", cart_loading, 1);
        check("attached_clear", cart_attached, 0);
        check("error_clear", load_error, 0);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(15) == 0) begin
                bus.dl_wr = 1'b0;
                @(posedge clk32); #1;
            end
            bus.dl_wr = 1'b1;
            bus.dl_data = img[i];
            dcyc.push_back(cyc);
            @(posedge clk32); #1;
        end
        bus.dl_wr = 1'b0;
        bus.dl_active = 1'b0;
        @(posedge clk32); #1;
        check("loading_end", cart_loading, 0);
        check("attached", cart_attached, m_att);
        check("load_error", load_error, m_err);
        if (m_att) begin
            check("cart_id", cart_id, m_id);
            check("cart_exrom", cart_exrom, m_ex);
            check("cart_game", cart_game, m_gm);
        end
        check("n_writes", got_wa.size(), exp_wa.size());
        for (int i = 0; i < exp_wa.size() && i < got_wa.size(); i++) begin
            check("write", got_wa[i], exp_wa[i]);
            check("write_latency", got_wc[i], dcyc[exp_wi[i]] + 1);
        end
        check("n_banks", got_d.size(), exp_d.size());
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            check("bank_raddr", got_d[i][79:56], exp_d[i][79:56]);
            check("bank_fields", got_d[i][55:0], exp_d[i][55:0]);
            check("bank_latency", got_dc[i], dcyc[exp_di[i]] + 1);
        end
    endtask
    initial begin
        int hl, n;
        bus.dl_active = 1'b0;
        bus.dl_wr = 1'b0;
        bus.dl_data = 8'h00;
        repeat (3) @(posedge clk32);
        #1;
        check("reset_status", {bus.mem_wr, cart_bank_wr, cart_loading, cart_attached, load_error}, 0);
        check("reset_fields", {cart_id, cart_exrom, cart_game, cart_bank_raddr}, 0);
        check("reset_bank", {cart_bank_num, cart_bank_laddr, cart_bank_size, cart_bank_type, bus.mem_addr}, 0);
        reset = 1'b1;
        // generic 8K
        mk_hdr('h40, 16'h0000, 8'h00, 8'h01);
        mk_chip('h2000, 0, 16'h0000, 16'h0000, 16'h8000);
        load(img.size());
        check("t1_raddr", raddr_of(0), 24'h100000);
        check("t1_nwr", got_wa.size(), 8192);
        check("t1_last", last_waddr(), 24'h101FFF);
        check("t1_game", cart_game, 1);
        @(posedge clk32); #1 cart_detach = 1'b1;
        @(posedge clk32); #1 cart_detach = 1'b0;
        check("detach", cart_attached, 0);
        // two chips behind an extended header
        mk_hdr('h50, 16'h0005, 8'h01, 8'h00);
        mk_chip('h4000, 0, 16'h0000, 16'h0000, 16'h8000);
        mk_chip('h1000, 0, 16'h0000, 16'h0001, 16'hA000);
        load(img.size());
        check("t2_raddr1", raddr_of(1), 24'h104000);
        check("t2_last", last_waddr(), 24'h104FFF);
        check("t2_nwr", got_wa.size(), 'h5000);
        // padded chip
        mk_hdr('h40, 16'h0013, 8'h00, 8'h00);
        mk_chip('h2000, 16, 16'h0000, 16'h0000, 16'h8000);
        mk_chip('h100, 0, 16'h0002, 16'h0001, 16'h8000);
        load(img.size());
        check("t3_raddr1", raddr_of(1), 24'h102000);
        check("t3_nwr", got_wa.size(), 'h2100);
        // bad signature
        mk_hdr('h40, 16'h0000, 8'h00, 8'h01);
        mk_chip('h200, 0, 16'h0000, 16'h0000, 16'h8000);
        img[5] = img[5] ^ 8'($urandom_range(1, 255));
        load(img.size());
        check("t4_error", load_error, 1);
        check("t4_none", got_wa.size() + got_d.size(), 0);
        // truncated inside chip data
        mk_hdr('h40, 16'h0000, 8'h00, 8'h01);
        mk_chip('h2000, 0, 16'h0000, 16'h0000, 16'h8000);
        load(64 + 16 + 'h1000);
        check("t5_trunc_att", cart_attached, 1);
        // reset in the middle of the header
        got_wa.delete(); got_d.delete();
        bus.dl_active = 1'b1;
        @(posedge clk32); #1;
        for (int i = 0; i < 40; i++) begin
            reset = !(i >= 30 && i < 32);
            bus.dl_wr = 1'b1;
            bus.dl_data = img[i];
            @(posedge clk32); #1;
        end
        reset = 1'b1;
        bus.dl_wr = 1'b0;
        check("rst_loading", cart_loading, 0);
        check("rst_attached", cart_attached, 0);
        bus.dl_active = 1'b0;
        repeat (2) @(posedge clk32);
        #1;
        check("rst_none", got_wa.size() + got_d.size(), 0);
        check("rst_status", {cart_attached, load_error, cart_loading}, 0);
        load(img.size());
        check("t5_raddr", raddr_of(0), 24'h100000);
        check("t5_nwr", got_wa.size(), 8192);
        // overflow: five small chips, each taking an 8K slot of a 32K region
        mk_hdr('h40, 16'h0020, 8'h00, 8'h00);
        for (int c = 0; c < 5; c++) mk_chip(16, 0, 16'h0000, 16'(c), 16'h8000);
        load(img.size());
        check("t6_raddr", raddr_of(4), 24'h108000);
        check("t6_nwr", got_wa.size(), 64);
        check("t6_status", {cart_attached, load_error}, 2'b01);
        // randomized images
        for (int r = 0; r < 6; r++) begin
            case ($urandom_range(3))
                0: hl = 'h20;
                1: hl = 'h40;
                2: hl = 'h48;
                default: hl = 'h50;
            endcase
            mk_hdr(hl, 16'($urandom), 8'($urandom), 8'($urandom));
            for (int c = $urandom_range(1, 3); c > 0; c--)
                mk_chip($urandom_range(0, 600), $urandom_range(1) == 0 ? $urandom_range(1, 24) : 0,
                        16'($urandom), 16'($urandom), 16'($urandom));
            if ($urandom_range(5) == 0) img[$urandom_range(15)] ^= 8'h20;
            n = $urandom_range(2) == 0 ? $urandom_range(1, img.size()) : img.size();
            load(n);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
